// File: rtl/uart_hex_sender.sv
// Prints a 32-bit word into the UART TX FIFO as ASCII hex, MS digit first,
// with an optional space / CR LF / LF terminator, one byte per non-full cycle.
module uart_hex_sender #(
  parameter int NDIG  = 8,
  parameter bit UPPER = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hex_start,
  input  logic [31:0] hex_word,
  input  logic [1:0]  hex_term,
  output logic        busy,
  output logic        done,
  output logic [7:0]  tx_wdata,
  output logic        tx_wten,
  input  logic        tx_fifo_full
);

  localparam int SH = 4 * (8 - NDIG);

  typedef enum logic [2:0] {
    IDLE,
    DIGIT,
    TERM1,
    TERM2,
    DONE
  } state_t;

  state_t      state, state_n;
  logic [31:0] shift_reg;
  logic [3:0]  cnt;
  logic [1:0]  term;
  logic        load, adv, wten;
  logic [7:0]  wbyte;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return (UPPER ? 8'h41 : 8'h61) + {4'h0, n} - 8'd10;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shift_reg <= '0;
      cnt       <= '0;
      term      <= '0;
    end else begin
      state <= state_n;
      if (load) begin
        shift_reg <= hex_word << SH;
        cnt       <= 4'(NDIG);
        term      <= hex_term;
      end else if (adv) begin
        shift_reg <= {shift_reg[27:0], 4'h0};
        cnt       <= cnt - 4'd1;
      end
    end
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    adv     = 1'b0;
    wten    = 1'b0;
    wbyte   = 8'h00;
    unique case (state)
      IDLE: begin
        if (hex_start) begin
          load    = 1'b1;
          state_n = DIGIT;
        end
      end
      DIGIT: begin
        wten  = ~tx_fifo_full;
        wbyte = hex_char(shift_reg[31:28]);
        if (wten) begin
          adv = 1'b1;
          if (cnt == 4'd1)
            state_n = (term == 2'b00) ? DONE : TERM1;
        end
      end
      TERM1: begin
        wten = ~tx_fifo_full;
        unique case (1'b1)
          term == 2'b01: wbyte = 8'h20;
          term == 2'b10: wbyte = 8'h0D;
          default:       wbyte = 8'h0A;
        endcase
        if (wten)
          state_n = (term == 2'b10) ? TERM2 : DONE;
      end
      TERM2: begin
        wten  = ~tx_fifo_full;
        wbyte = 8'h0A;
        if (wten) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign tx_wten  = wten;
  assign tx_wdata = wten ? wbyte : 8'h00;

endmodule

// File: tb/tb_uart_hex_sender.sv
// Directed bench for uart_hex_sender: byte order, timing, backpressure,
// start-while-busy, narrow/uppercase build and asynchronous reset.
module tb_uart_hex_sender;

  typedef logic [7:0] bq_t [$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic [31:0] word = '0;
  logic [1:0]  term = '0;
  logic        full = 1'b0;
  logic        busy0, done0, wten0, busy1, done1, wten1;
  logic [7:0]  wdata0, wdata1;

  int   n_cmp = 0, n_err = 0;
  int   cyc = 0;
  logic [7:0] q [$];
  int   qc [$];
  int   done_cyc = -1;
  int   done_n = 0;
  int   t;
  bq_t  e;

  uart_hex_sender #(.NDIG(8), .UPPER(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .hex_start(start0), .hex_word(word),
    .hex_term(term), .busy(busy0), .done(done0), .tx_wdata(wdata0),
    .tx_wten(wten0), .tx_fifo_full(full)
  );

  uart_hex_sender #(.NDIG(2), .UPPER(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .hex_start(start1), .hex_word(word),
    .hex_term(term), .busy(busy1), .done(done1), .tx_wdata(wdata1),
    .tx_wten(wten1), .tx_fifo_full(full)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wten0) begin q.push_back(wdata0); qc.push_back(cyc); end
    if (wten1) begin q.push_back(wdata1); qc.push_back(cyc); end
    if (done0 || done1) begin done_cyc = cyc; done_n++; end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic inst, input logic [31:0] w,
                       input logic [1:0] tm, output int ts);
    q.delete();
    qc.delete();
    done_cyc = -1;
    done_n   = 0;
    word = w;
    term = tm;
    if (inst) start1 = 1'b1;
    else      start0 = 1'b1;
    ts = cyc;
    step();
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (done_cyc >= 0) break;
      step();
    end
    chk({tag, "_done_seen"}, 32'(done_cyc >= 0), 32'd1);
  endtask

  task automatic check_run(input string tag, input bq_t eb, input int ts,
                           input int stall, input int done_rel);
    chk({tag, "_nbytes"}, q.size(), eb.size());
    foreach (eb[i]) begin
      if (i < q.size()) begin
        chk($sformatf("%s_b%0d", tag, i), 32'(q[i]), 32'(eb[i]));
        chk($sformatf("%s_c%0d", tag, i), qc[i] - ts,
            1 + i + ((i >= 2) ? stall : 0));
      end
    end
    chk({tag, "_done_at"}, done_cyc - ts, done_rel);
    chk({tag, "_done_once"}, done_n, 1);
  endtask

  initial begin
    #2;
    chk("rst_busy0", 32'(busy0), 0);
    chk("rst_done0", 32'(done0), 0);
    chk("rst_wten0", 32'(wten0), 0);
    chk("rst_wdata0", 32'(wdata0), 0);
    chk("rst_busy1", 32'(busy1), 0);
    chk("rst_wten1", 32'(wten1), 0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // 1: full word with CR LF
    start(1'b0, 32'h1234ABCD, 2'b10, t);
    chk("t1_busy", 32'(busy0), 1);
    wait_done("t1", 40);
    e = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h61, 8'h62, 8'h63, 8'h64,
          8'h0D, 8'h0A};
    check_run("t1", e, t, 0, 11);
    chk("t1_idle_cyc", cyc - t, 12);
    chk("t1_busy_end", 32'(busy0), 0);
    step();

    // 2: zeros, no terminator
    start(1'b0, 32'h0, 2'b00, t);
    wait_done("t2", 40);
    e = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30};
    check_run("t2", e, t, 0, 9);
    step();

    // 3: backpressure on t+3..t+5
    start(1'b0, 32'hDEADBEEF, 2'b01, t);
    step();
    for (int k = 0; k < 3; k++) begin
      step();
      full = 1'b1;
      #1;
      chk($sformatf("t3_stall_wten%0d", k), 32'(wten0), 0);
      chk($sformatf("t3_stall_wdata%0d", k), 32'(wdata0), 0);
      chk($sformatf("t3_stall_busy%0d", k), 32'(busy0), 1);
    end
    step();
    full = 1'b0;
    wait_done("t3", 40);
    e = '{8'h64, 8'h65, 8'h61, 8'h64, 8'h62, 8'h65, 8'h65, 8'h66, 8'h20};
    check_run("t3", e, t, 3, 13);
    step();

    // 4: two uppercase digits, LF only
    start(1'b1, 32'hFFFFFF5A, 2'b11, t);
    wait_done("t4", 20);
    e = '{8'h35, 8'h41, 8'h0A};
    check_run("t4", e, t, 0, 4);
    step();

    // 5: starts while busy are ignored, input changes have no effect
    start(1'b0, 32'h12345678, 2'b01, t);
    repeat (3) step();
    start0 = 1'b1;
    word   = 32'h11111111;
    term   = 2'b10;
    step();
    start0 = 1'b0;
    repeat (5) step();
    chk("t5_done_cycle", 32'(done0), 1);
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    chk("t5_not_reaccepted", 32'(busy0), 0);
    repeat (4) step();
    e = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h20};
    check_run("t5", e, t, 0, 10);
    chk("t5_still_idle", 32'(busy0), 0);

    // 6: asynchronous reset mid-transfer
    start(1'b0, 32'h1234ABCD, 2'b10, t);
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_wten", 32'(wten0), 0);
    chk("t6_rst_busy", 32'(busy0), 0);
    chk("t6_rst_done", 32'(done0), 0);
    chk("t6_rst_wdata", 32'(wdata0), 0);
    chk("t6_bytes_before", q.size(), 4);
    step();
    rst_n = 1'b1;
    step();
    chk("t6_idle_after", 32'(busy0), 0);
    chk("t6_no_writes", q.size(), 4);
    start(1'b0, 32'h1234ABCD, 2'b10, t);
    wait_done("t6", 40);
    e = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h61, 8'h62, 8'h63, 8'h64,
          8'h0D, 8'h0A};
    check_run("t6", e, t, 0, 11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
